lane_packer: RTL and testbench



---
 rtl/lane_packer_pkg.sv | 32 +++
 rtl/lane_packer_slot.sv | 42 ++++
 rtl/lane_packer.sv | 104 ++++++++++
 tb/tb_lane_packer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_packer_pkg.sv
// Shared constants, slot state encoding and sizing/mask helpers for lane_packer.
// The optional packet-end feature is enabled by defining PAR_PACKER_LAST_EN.
package lane_packer_pkg;

    localparam int LANE_BITS_DEF     = 16;
    localparam int PAR_GLB_DATA_BITS = 64;
    localparam int MAX_LANES         = 64;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int lane_count(input int out_bits, input int lane_bits);
        return out_bits / lane_bits;
    endfunction

    // A 2-lane packer still needs one counter bit.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_LANES-1:0] keep_mask(input int idx);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i <= idx) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_packer_slot.sv
// Output holding register for lane_packer: one word slot with valid/ready,
// loaded by a completing lane and held stable until the downstream accepts it.
module lane_packer_slot
    import lane_packer_pkg::*;
#(
    parameter int PAY_BITS = 64
) (
    input  logic                ib_clk,
    input  logic                ib_rst,
    input  logic                ib_load,
    input  logic [PAY_BITS-1:0] ivG_load_data,
    input  logic                ib_out_ready,
    output logic                ob_out_valid,
    output logic [PAY_BITS-1:0] ovG_out_data
);

    slot_state_e state_q, state_d;

    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            state_q      <= SLOT_EMPTY;
            ovG_out_data <= '0;
        end else begin
            state_q <= state_d;
            if (ib_load) ovG_out_data <= ivG_load_data;
        end
    end

    // A load while FULL only arrives together with a word handshake, so it is a reload.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (ib_load) state_d = SLOT_FULL;
            SLOT_FULL:  if (ib_out_ready && !ib_load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    assign ob_out_valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/lane_packer.sv
// Width-up packer: gathers narrow lanes into full words, lane 0 in the LSB slot.
// Define PAR_PACKER_LAST_EN to add in_last / out_keep / out_last packet framing.
module lane_packer
    import lane_packer_pkg::*;
#(
    parameter int PAR_OUT_BITS  = PAR_GLB_DATA_BITS,
    parameter int PAR_LANE_BITS = LANE_BITS_DEF,
    localparam int N            = lane_count(PAR_OUT_BITS, PAR_LANE_BITS),
    localparam int CW           = count_width(N)
) (
    input  logic                     ib_clk,
    input  logic                     ib_rst,
    input  logic                     ib_in_valid,
    output logic                     ob_in_ready,
    input  logic [PAR_LANE_BITS-1:0] ivG_in_data,
`ifdef PAR_PACKER_LAST_EN
    input  logic                     ib_in_last,
`endif
    output logic                     ob_out_valid,
    input  logic                     ib_out_ready,
    output logic [PAR_OUT_BITS-1:0]  ovG_out_data
`ifdef PAR_PACKER_LAST_EN
    ,
    output logic [N-1:0]             ovG_out_keep,
    output logic                     ob_out_last
`endif
);

    logic [CW-1:0]           cnt;
    logic [PAR_OUT_BITS-1:0] asm_q;
    logic [PAR_OUT_BITS-1:0] word;
    logic                    closes_word;
    logic                    accept;
    logic                    complete;

`ifdef PAR_PACKER_LAST_EN
    assign closes_word = (cnt == CW'(N - 1)) || ib_in_last;
`else
    assign closes_word = (cnt == CW'(N - 1));
`endif

    // A completing lane may only enter when the slot is free or being drained now.
    assign ob_in_ready = !ib_rst && !(closes_word && ob_out_valid && !ib_out_ready);
    assign accept      = ib_in_valid && ob_in_ready;
    assign complete    = accept && closes_word;

    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= complete ? '0 : cnt + CW'(1);
        end
    end

    // NOTE: the assembly register is pure datapath and deliberately has no reset;
    // every slot that reaches the output is written (or zero-filled) first.
    always_ff @(posedge ib_clk) begin
        if (accept) asm_q[int'(cnt)*PAR_LANE_BITS +: PAR_LANE_BITS] <= ivG_in_data;
    end

    // Word as it will look once the current lane lands in slot cnt.
    always_comb begin
        word = asm_q;
        for (int i = 0; i < N; i++) begin
            if (i == int'(cnt)) begin
                word[i*PAR_LANE_BITS +: PAR_LANE_BITS] = ivG_in_data;
            end
`ifdef PAR_PACKER_LAST_EN
            else if (i > int'(cnt)) begin
                word[i*PAR_LANE_BITS +: PAR_LANE_BITS] = '0;
            end
`endif
        end
    end

`ifdef PAR_PACKER_LAST_EN
    localparam int PAY_BITS = PAR_OUT_BITS + N + 1;
    logic [N-1:0]        keep;
    logic [PAY_BITS-1:0] pay_in, pay_out;

    assign keep   = N'(keep_mask(int'(cnt)));
    assign pay_in = {ib_in_last, keep, word};
    assign {ob_out_last, ovG_out_keep, ovG_out_data} = pay_out;
`else
    localparam int PAY_BITS = PAR_OUT_BITS;
    logic [PAY_BITS-1:0] pay_in, pay_out;

    assign pay_in       = word;
    assign ovG_out_data = pay_out;
`endif

    lane_packer_slot #(
        .PAY_BITS (PAY_BITS)
    ) u_slot (
        .ib_clk        (ib_clk),
        .ib_rst        (ib_rst),
        .ib_load       (complete),
        .ivG_load_data (pay_in),
        .ib_out_ready  (ib_out_ready),
        .ob_out_valid  (ob_out_valid),
        .ovG_out_data  (pay_out)
    );

endmodule

// File: tb/tb_lane_packer.sv
// Self-checking bench for lane_packer (N=4 x 16-bit): a lane/word queue model
// checked every cycle, plus directed scenarios pinned with literal words.
module tb_lane_packer;

    localparam int LB = 16;
    localparam int OB = 64;
    localparam int N  = OB / LB;

    typedef struct {
        logic [OB-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [LB-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OB-1:0] out_data;
`ifdef PAR_PACKER_LAST_EN
    logic [N-1:0]  out_keep;
    logic          out_last;
`endif

    int errors = 0;
    int checks = 0;

    lane_packer #(
        .PAR_OUT_BITS  (OB),
        .PAR_LANE_BITS (LB)
    ) dut (
        .ib_clk       (clk),
        .ib_rst       (rst),
        .ib_in_valid  (in_valid),
        .ob_in_ready  (in_ready),
        .ivG_in_data  (in_data),
`ifdef PAR_PACKER_LAST_EN
        .ib_in_last   (in_last),
`endif
        .ob_out_valid (out_valid),
        .ib_out_ready (out_ready),
        .ovG_out_data (out_data)
`ifdef PAR_PACKER_LAST_EN
        ,
        .ovG_out_keep (out_keep),
        .ob_out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [LB-1:0] part_q[$];
    exp_t          exp_q[$];
    logic [OB-1:0] got_data[$];
    logic [N-1:0]  got_keep[$];
    logic          got_last[$];
    int            got_cyc[$];
    int            cyc = 0;
    int            stall_cycles = 0;
    int            valid_cycles = 0;
    logic          mon_en = 1'b0;

    function automatic exp_t build_word(input logic is_last);
        exp_t e;
        e.data = '0;
        for (int i = 0; i < part_q.size(); i++) e.data[i*LB +: LB] = part_q[i];
        e.keep = N'((1 << part_q.size()) - 1);
        e.last = is_last;
        return e;
    endfunction

    always @(negedge clk) begin
        logic would_complete;
        logic lane_last;
        exp_t e;
        cyc++;
`ifdef PAR_PACKER_LAST_EN
        lane_last = in_last;
`else
        lane_last = 1'b0;
`endif
        if (mon_en) begin
            would_complete = (part_q.size() == N - 1) || lane_last;
            check("in_ready", in_ready,
                  !rst && !(would_complete && exp_q.size() != 0 && !out_ready));
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0 && out_valid) begin
                check("out_data", out_data, exp_q[0].data);
`ifdef PAR_PACKER_LAST_EN
                check("out_keep", out_keep, exp_q[0].keep);
                check("out_last", out_last, exp_q[0].last);
`endif
            end
            if (in_valid && !in_ready) stall_cycles++;
            if (out_valid) valid_cycles++;

            if (rst) begin
                part_q.delete();
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    got_data.push_back(out_data);
`ifdef PAR_PACKER_LAST_EN
                    got_keep.push_back(out_keep);
                    got_last.push_back(out_last);
`endif
                    got_cyc.push_back(cyc);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    part_q.push_back(in_data);
                    if (part_q.size() == N || lane_last) begin
                        e = build_word(lane_last);
                        exp_q.push_back(e);
                        part_q.delete();
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_lane(input logic [LB-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("lane_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((out_valid || exp_q.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_done", out_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, s, v;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; mon_en = 1'b1;
        @(posedge clk); #1; rst = 1'b0;

        // Reset state, first cycle after reset
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
`ifdef PAR_PACKER_LAST_EN
        check("rst_out_keep", out_keep, 4'b0000);
        check("rst_out_last", out_last, 1'b0);
`endif
        @(posedge clk); #1;

        // T1: one word, back-to-back lanes
        b = got_data.size(); v = valid_cycles;
        send_lane(16'h1111, 0); send_lane(16'h2222, 0);
        send_lane(16'h3333, 0); send_lane(16'h4444, 0);
        drain();
        check("t1_words", got_data.size() - b, 1);
        check("t1_word", got_data[b], 64'h4444_3333_2222_1111);
        check("t1_valid_cycles", valid_cycles - v, 1);

        // T2: 8 lanes continuous, no bubble at the wrap
        b = got_data.size(); s = stall_cycles;
        for (int i = 0; i < 8; i++) send_lane(LB'(16'h0100 + i), 0);
        drain();
        check("t2_words", got_data.size() - b, 2);
        check("t2_word0", got_data[b], 64'h0103_0102_0101_0100);
        check("t2_word1", got_data[b+1], 64'h0107_0106_0105_0104);
        check("t2_spacing", got_cyc[b+1] - got_cyc[b], 4);
        check("t2_no_stall", stall_cycles - s, 0);

        // T3: first word held 5 cycles, completing lane of the next waits
        b = got_data.size();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_lane(LB'(16'h1000 + i), 0);
        s = stall_cycles;
        fork
            for (int i = 1; i <= 4; i++) send_lane(LB'(16'h2000 + i), 0);
            begin repeat (5) @(posedge clk); #1; out_ready = 1'b1; end
        join
        drain();
        check("t3_words", got_data.size() - b, 2);
        check("t3_word0", got_data[b], 64'h1004_1003_1002_1001);
        check("t3_word1", got_data[b+1], 64'h2004_2003_2002_2001);
        check("t3_stall_cycles", stall_cycles - s, 2);
        check("t3_reload_gap", got_cyc[b+1] - got_cyc[b], 1);

        // T4: reset after 2 lanes discards the partial word
        b = got_data.size();
        send_lane(16'h5555, 0); send_lane(16'h6666, 0);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("t4_in_ready", in_ready, 1'b1);
        check("t4_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        send_lane(16'h000A, 0); send_lane(16'h000B, 0);
        send_lane(16'h000C, 0); send_lane(16'h000D, 0);
        drain();
        check("t4_words", got_data.size() - b, 1);
        check("t4_word", got_data[b], 64'h000D_000C_000B_000A);

`ifdef PAR_PACKER_LAST_EN
        // T5: short packet closed by last
        b = got_data.size();
        send_lane(16'h0001, 0); send_lane(16'h0002, 1);
        send_lane(16'h0003, 0); send_lane(16'h0004, 0);
        send_lane(16'h0005, 0); send_lane(16'h0006, 0);
        drain();
        check("t5_words", got_data.size() - b, 2);
        check("t5_word", got_data[b], 64'h0000_0000_0002_0001);
        check("t5_keep", got_keep[b], 4'b0011);
        check("t5_last", got_last[b], 1'b1);
        check("t5_next_word", got_data[b+1], 64'h0006_0005_0004_0003);
        check("t5_next_keep", got_keep[b+1], 4'b1111);
        check("t5_next_last", got_last[b+1], 1'b0);

        // T6: last on the 4th lane while the output is stalled
        b = got_data.size();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_lane(LB'(16'h3000 + i), 0);
        s = stall_cycles;
        fork
            for (int i = 1; i <= 4; i++) send_lane(LB'(16'h4000 + i), i == 4);
            begin repeat (5) @(posedge clk); #1; out_ready = 1'b1; end
        join
        drain();
        check("t6_words", got_data.size() - b, 2);
        check("t6_word1", got_data[b+1], 64'h4004_4003_4002_4001);
        check("t6_keep", got_keep[b+1], 4'b1111);
        check("t6_last", got_last[b+1], 1'b1);
        check("t6_stall_cycles", stall_cycles - s, 2);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
